// File: rtl/tree_ack_pkg.sv
// Shared types and limits for the tree acknowledge aggregator node.
package tree_ack_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam int MAX_CHILDREN         = 32;
   localparam int DEFAULT_NUM_CHILDREN = 10;

endpackage

// File: rtl/tree_ack_timeout.sv
// Collect-phase watchdog: counts enabled cycles, flags the last allowed one.
module tree_ack_timeout #(
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMEOUT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tree_ack_aggregator.sv
// Fan-in node: forwards a parent request to enabled children and returns one
// aggregated ack once all of them answer. TREE_ACK_TIMEOUT_EN adds an abort timer.
module tree_ack_aggregator
   import tree_ack_pkg::*;
#(
   parameter int NUM_CHILDREN   = DEFAULT_NUM_CHILDREN,
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_i,
   output logic                    req_ready_o,
   input  logic [NUM_CHILDREN-1:0] child_en_i,
   output logic [NUM_CHILDREN-1:0] child_req_o,
   input  logic [NUM_CHILDREN-1:0] child_ack_i,
   output logic                    ack_o,
   input  logic                    ack_ready_i,
   output logic                    ack_err_o,
   output logic [NUM_CHILDREN-1:0] ack_mask_o
);

   // Handshakes: a request transfers on req_i && req_ready_o; the aggregated
   // ack transfers on ack_o && ack_ready_i and is held stable until then.

   state_t                  state, state_n;
   logic [NUM_CHILDREN-1:0] pending, pending_n;
   logic [NUM_CHILDREN-1:0] done, done_n;
   logic [NUM_CHILDREN-1:0] hit;
   logic                    ack_err, ack_err_n;
   logic                    expired;

`ifdef TREE_ACK_TIMEOUT_EN
   tree_ack_timeout #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != COLLECT),
      .enable  (state == COLLECT),
      .expired (expired)
   );
   assign ack_err_o = ack_err;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^{TIMEOUT_W, TIMEOUT_CYCLES, ack_err};
   assign expired   = 1'b0;
   assign ack_err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         done    <= '0;
         ack_err <= 1'b0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
         done    <= done_n;
         ack_err <= ack_err_n;
      end
   end

   always_comb begin
      state_n   = state;
      pending_n = pending;
      done_n    = done;
      ack_err_n = ack_err;
      hit       = pending & child_ack_i;
      case (state)
         IDLE: begin
            if (req_i) begin
               pending_n = child_en_i;
               done_n    = '0;
               ack_err_n = 1'b0;
               state_n   = (child_en_i == '0) ? RESPOND : COLLECT;
            end
         end
         COLLECT: begin
            pending_n = pending & ~hit;
            done_n    = done | hit;
            if (pending_n == '0) begin
               state_n = RESPOND;
            end else if (expired) begin
               // Abort keeps whatever acked, including on this very edge.
               pending_n = '0;
               ack_err_n = 1'b1;
               state_n   = RESPOND;
            end
         end
         RESPOND: begin
            if (ack_ready_i) begin
               ack_err_n = 1'b0;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign req_ready_o = (state == IDLE);
   assign child_req_o = (state == COLLECT) ? pending : '0;
   assign ack_o       = (state == RESPOND);
   assign ack_mask_o  = (state == RESPOND) ? done : '0;

endmodule
